local_out: RTL
==============

# local_out

Router ingress stage that takes spike packets from the core's local output FIFO and injects them into the mesh. It decodes the signed dx/dy offsets and forwards each packet to the east, west, north, south or local-loopback output buffer. It updates the hop offsets and strips dx once horizontal travel is complete. It is the counterpart of the local-in merge, which delivers stripped packets from the mesh to the core.

## Interface
- DX_WIDTH, 9, signed two's-complement x offset width
- DY_WIDTH, 9, signed two's-complement y offset width
- PAYLOAD_WIDTH, 12, payload width; the packet delivered to the core is payload only
- clk  input  1  clock; all logic is on the rising edge
- rst  input  1  reset; synchronous and active-high
- din  input  DX_WIDTH+DY_WIDTH+PAYLOAD_WIDTH  packet {dx, dy, payload} from the core FIFO; first-word-fall-through, valid whenever empty=0
- empty  input  1  core FIFO empty
- ren  output  1  pops din this cycle
- dout_east, dout_west  output  DX_WIDTH+DY_WIDTH+PAYLOAD_WIDTH  {dx', dy, payload}
- dout_north, dout_south  output  DY_WIDTH+PAYLOAD_WIDTH  {dy', payload}
- dout_local  output  PAYLOAD_WIDTH  payload
- wen_east, wen_west, wen_north, wen_south, wen_local  output  1  write strobe to the matching output buffer
- full_east, full_west, full_north, full_south, full_local  input  1  output buffer full
- busy  output  1  stage register holds a packet

## Operation
- There is a single stage register with a valid bit, a 3-bit destination code and a formatted packet.
- FSM states:
  - EMPTY (valid=0)
  - HELD (valid=1)
- Routing decision, evaluated on din at capture:
  - dx>0: east, dx'=dx-1
  - dx<0: west, dx'=dx+1
  - dx==0, dy>0: north, dy'=dy-1
  - dx==0, dy<0: south, dy'=dy+1
  - dx==0, dy==0: local
- Offset arithmetic always moves toward zero, so there is no overflow, including at dx=-2^(DX_WIDTH-1). Results are truncated to the field width.
- drain = HELD && !full_dest.
- ren = !empty && (EMPTY || drain). When ren is high, the stage loads din. This gives the transitions:
  - EMPTY to HELD when ren is high.
  - HELD to HELD on drain together with ren (back-to-back transfer).
  - HELD to EMPTY on drain without ren.
  - HELD to HELD with no change while full_dest is high (stall).
- wen_dest = drain. It is combinational from the stage register and the full inputs. All other wen outputs are 0.
- At most one wen is high per cycle.
- dout_* buses are driven from the stage register. Unselected buses hold their last value. Consumers qualify on wen only.
- The full flags of non-selected destinations are ignored. There is no head-of-line bypass.

## Timing
- Reset values: ren=0, all wen=0, busy=0, all dout=0, state EMPTY.
- While rst is high, ren=0 regardless of empty.
- Latency: din is popped in cycle t and wen_dest is high in cycle t+1 if the destination is not full.
- Throughput is 1 packet per cycle while the destination never asserts full.
- Stall: while full_dest=1, the stage and dout hold, wen=0 and ren=0. In the first cycle full_dest=0, wen=1 and, if !empty, ren=1 in the same cycle.
- empty rising in the same cycle as drain: stage goes to EMPTY, busy=0 next cycle.
- rst asserted in HELD: the packet is discarded, no wen is issued, and the state is EMPTY in the next cycle.
- full_* may change every cycle. wen is combinational from full within that cycle.

## Test plan
- dx=3, dy=-2 (9'h1FE), payload 12'hABC, all not full -> ren at t; at t+1 wen_east=1, dout_east={9'd2, 9'h1FE, 12'hABC}; other wen=0.
- dx=-1 (9'h1FF), dy=4 -> wen_west with dx'=0, dy=4. Then dx=0, dy=4 -> wen_north, dout_north={9'd3, payload}.
- dx=0, dy=-256 (9'h100), payload 12'h001 -> wen_south, dout_south={9'h101, 12'h001}. dx=0, dy=0, payload 12'h5A5 -> wen_local, dout_local=12'h5A5.
- Four queued east packets, full_east high for 3 cycles after the first capture -> ren stays 0 and busy=1 during the stall. Once full_east drops, wen_east and ren are high together and the remaining packets deliver one per cycle, in order.
- Alternate the destinations east/north/local on consecutive packets with no full -> each cycle exactly one matching wen is high, and there are no bubbles.
- Assert rst for 1 cycle while HELD with full_north=1 -> next cycle busy=0, all wen=0, and the dropped packet is never written. The next FIFO packet routes normally.

Source files
------------

// File: rtl/local_out.sv
// local_out: router ingress stage from the core's local output FIFO.
// Captures one packet at a time, decodes its signed dx/dy hop offsets and
// presents it to exactly one of the east/west/north/south/local output
// buffers, with the offset for that hop already moved one step toward zero.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   din, empty, ren     first-word-fall-through core FIFO: {dx, dy, payload}
//   dout_east/west      {dx', dy, payload} toward horizontal neighbours
//   dout_north/south    {dy', payload} once horizontal travel is done
//   dout_local          payload looped back to the core
//   wen_*               write strobe, one-hot, to the matching buffer
//   full_*              output buffer full flags
//   busy                stage register holds a packet
module local_out #(
  parameter int DX_WIDTH      = 9,
  parameter int DY_WIDTH      = 9,
  parameter int PAYLOAD_WIDTH = 12
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [DX_WIDTH+DY_WIDTH+PAYLOAD_WIDTH-1:0] din,
  input  logic                                      empty,
  output logic                                      ren,
  output logic [DX_WIDTH+DY_WIDTH+PAYLOAD_WIDTH-1:0] dout_east,
  output logic [DX_WIDTH+DY_WIDTH+PAYLOAD_WIDTH-1:0] dout_west,
  output logic [DY_WIDTH+PAYLOAD_WIDTH-1:0]          dout_north,
  output logic [DY_WIDTH+PAYLOAD_WIDTH-1:0]          dout_south,
  output logic [PAYLOAD_WIDTH-1:0]                   dout_local,
  output logic                                      wen_east,
  output logic                                      wen_west,
  output logic                                      wen_north,
  output logic                                      wen_south,
  output logic                                      wen_local,
  input  logic                                      full_east,
  input  logic                                      full_west,
  input  logic                                      full_north,
  input  logic                                      full_south,
  input  logic                                      full_local,
  output logic                                      busy
);

  typedef enum logic {EMPTY, HELD} state_t;
  typedef enum logic [2:0] {
    DEST_EAST  = 3'd0,
    DEST_WEST  = 3'd1,
    DEST_NORTH = 3'd2,
    DEST_SOUTH = 3'd3,
    DEST_LOCAL = 3'd4
  } dest_t;

  state_t state;
  dest_t  dest;
  dest_t  next_dest;

  logic [DX_WIDTH-1:0]      dx;
  logic [DY_WIDTH-1:0]      dy;
  logic [PAYLOAD_WIDTH-1:0] payload;
  logic [DX_WIDTH-1:0]      dx_step;
  logic [DY_WIDTH-1:0]      dy_step;
  logic                     dest_full;
  logic                     drain;

  assign {dx, dy, payload} = din;

  // Offsets always step toward zero: negative values are incremented and
  // positive ones decremented, so even the most negative value cannot wrap.
  assign dx_step = dx[DX_WIDTH-1] ? dx + DX_WIDTH'(1) : dx - DX_WIDTH'(1);
  assign dy_step = dy[DY_WIDTH-1] ? dy + DY_WIDTH'(1) : dy - DY_WIDTH'(1);

  // Horizontal travel first; only once dx is exhausted does dy steer.
  always_comb begin
    next_dest = DEST_LOCAL;
    if (dx != '0)
      next_dest = dx[DX_WIDTH-1] ? DEST_WEST : DEST_EAST;
    else if (dy != '0)
      next_dest = dy[DY_WIDTH-1] ? DEST_SOUTH : DEST_NORTH;
  end

  // Only the held packet's own destination can stall it.
  always_comb begin
    case (dest)
      DEST_EAST:  dest_full = full_east;
      DEST_WEST:  dest_full = full_west;
      DEST_NORTH: dest_full = full_north;
      DEST_SOUTH: dest_full = full_south;
      default:    dest_full = full_local;
    endcase
  end

  // Gating with rst keeps a packet caught by reset from ever being written.
  assign drain = (state == HELD) && !dest_full && !rst;
  assign ren   = !rst && !empty && ((state == EMPTY) || drain);
  assign busy  = (state == HELD);

  assign wen_east  = drain && (dest == DEST_EAST);
  assign wen_west  = drain && (dest == DEST_WEST);
  assign wen_north = drain && (dest == DEST_NORTH);
  assign wen_south = drain && (dest == DEST_SOUTH);
  assign wen_local = drain && (dest == DEST_LOCAL);

  // Stage register: the per-destination dout registers double as the packet
  // store, so only the selected bus is reloaded and the others keep their
  // last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      dest       <= DEST_LOCAL;
      dout_east  <= '0;
      dout_west  <= '0;
      dout_north <= '0;
      dout_south <= '0;
      dout_local <= '0;
    end else begin
      if (ren) begin
        state <= HELD;
        dest  <= next_dest;
        case (next_dest)
          DEST_EAST:  dout_east  <= {dx_step, dy, payload};
          DEST_WEST:  dout_west  <= {dx_step, dy, payload};
          DEST_NORTH: dout_north <= {dy_step, payload};
          DEST_SOUTH: dout_south <= {dy_step, payload};
          default:    dout_local <= payload;
        endcase
      end else if (drain) begin
        state <= EMPTY;
      end
    end
  end

endmodule
